// File: rtl/serial_adder_nand_pkg.sv
// Shared types and constants for the bit-serial NAND adder.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

  // Default operand width used when the parent does not override N.
  localparam int SERIAL_ADDER_N_DEF = 8;

  // Controller states: wait for a request, shift one bit per clock, flag the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_nand_if.sv
// Request/result bundle for serial_adder_nand. The requester uses the master
// modport, the adder uses the slave modport.
// When SERIAL_ADDER_SUB_EN is defined the bundle also carries the 'sub' request bit.
interface serial_adder_nand_if
  import serial_adder_pkg::*;
#(
  parameter int N = SERIAL_ADDER_N_DEF
) ();

  // Request side: operands and carry-in are captured on an accepted start.
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif

  // Result side: all of these come straight from registers inside the adder.
  logic         ready;
  logic         done_tick;
  logic [N-1:0] sum;
  logic         cout;

  modport master (
    output start,
    output a,
    output b,
    output cin,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    input  ready,
    input  done_tick,
    input  sum,
    input  cout
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    output ready,
    output done_tick,
    output sum,
    output cout
  );

endinterface

// File: rtl/serial_adder_nand_full_adder_cell.sv
// One-bit full adder built exclusively from two-input NAND gates (nine of them),
// plus the NAND primitive it is made from. Purely combinational.

module nand_gate (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);

  assign o_y = ~(i_a & i_b);

endmodule

module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  // First half adder: w_abXor = a ^ b using four NANDs, w_abNand reused for carry.
  logic w_abNand;
  logic w_aSide;
  logic w_bSide;
  logic w_abXor;

  // Second half adder: sum = (a ^ b) ^ cin, w_xcNand reused for carry.
  logic w_xcNand;
  logic w_xSide;
  logic w_cSide;

  nand_gate u_n1 (.i_a(i_a),      .i_b(i_b),      .o_y(w_abNand));
  nand_gate u_n2 (.i_a(i_a),      .i_b(w_abNand), .o_y(w_aSide));
  nand_gate u_n3 (.i_a(i_b),      .i_b(w_abNand), .o_y(w_bSide));
  nand_gate u_n4 (.i_a(w_aSide),  .i_b(w_bSide),  .o_y(w_abXor));

  nand_gate u_n5 (.i_a(w_abXor),  .i_b(i_cin),    .o_y(w_xcNand));
  nand_gate u_n6 (.i_a(w_abXor),  .i_b(w_xcNand), .o_y(w_xSide));
  nand_gate u_n7 (.i_a(i_cin),    .i_b(w_xcNand), .o_y(w_cSide));
  nand_gate u_n8 (.i_a(w_xSide),  .i_b(w_cSide),  .o_y(o_sum));

  // Carry = ab | (a^b)cin, i.e. NAND of the two inverted partial carries.
  nand_gate u_n9 (.i_a(w_abNand), .i_b(w_xcNand), .o_y(o_cout));

endmodule

// File: rtl/serial_adder_nand.sv
// Bit-serial N-bit adder: one NAND full-adder cell plus a registered carry,
// processing operands LSB first, one bit per clock, under a start/done handshake.
// Latency: start accepted in cycle 0, done_tick in cycle N+1, ready again in N+2.
// Defining SERIAL_ADDER_SUB_EN adds a 'sub' request bit selecting a - b.
module serial_adder_nand
  import serial_adder_pkg::*;
#(
  parameter int N = SERIAL_ADDER_N_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  serial_adder_nand_if.slave  bus
);

  // Counter is sized to hold N so it never wraps inside one operation.
  localparam int                CNT_W    = $clog2(N + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N - 1);

  state_t           r_state;
  state_t           w_nextState;

  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic [N-1:0]     r_sum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_done;

  logic             w_accept;
  logic             w_lastBit;
  logic             w_bitSum;
  logic             w_bitCarry;
  logic [N-1:0]     w_bLoad;
  logic             w_cLoad;

  // Operand B and the initial carry: subtract mode feeds ~b with a forced
  // carry-in of 1 so the same adder produces a + ~b + 1 = a - b.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_bLoad = bus.sub ? ~bus.b : bus.b;
  assign w_cLoad = bus.sub ? 1'b1   : bus.cin;
`else
  assign w_bLoad = bus.b;
  assign w_cLoad = bus.cin;
`endif

  // The counter holds the index of the bit being added this cycle.
  assign w_lastBit = (r_cnt == LAST_CNT);

  // The single shared NAND cell works on the current LSBs and the stored carry.
  full_adder_cell u_cell (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_sum  (w_bitSum),
    .o_cout (w_bitCarry)
  );

  // State register plus the registered handshake flags derived from the next state,
  // so ready and done_tick change exactly together with the state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_ready <= (w_nextState == IDLE);
      r_done  <= (w_nextState == DONE);
    end
  end

  // Next-state logic; a start outside IDLE is simply not looked at.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_nextState = ADD;
        end
      end
      ADD: begin
        if (w_lastBit) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: capture operands on an accepted start, then shift one bit per ADD
  // cycle; outside those cases everything holds so the result stays visible.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= w_bLoad;
      r_carry <= w_cLoad;
      r_cnt   <= '0;
    end else if (r_state == ADD) begin
      r_a     <= {1'b0, r_a[N-1:1]};
      r_b     <= {1'b0, r_b[N-1:1]};
      r_sum   <= {w_bitSum, r_sum[N-1:1]};
      r_carry <= w_bitCarry;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // Every output is a plain register copy; no input reaches an output combinationally.
  assign bus.ready     = r_ready;
  assign bus.done_tick = r_done;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_carry;

endmodule

// File: tb/tb_serial_adder_nand.sv
// Directed self-checking bench for serial_adder_nand at N=8 and N=16.
// Subtract-mode vectors are included when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_nand;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  int   doneCount;
  int   quietDone;

  always #5 clk = ~clk;

  serial_adder_nand_if #(.N(8))  bus8  ();
  serial_adder_nand_if #(.N(16)) bus16 ();

  serial_adder_nand #(.N(8)) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus8)
  );

  serial_adder_nand #(.N(16)) dut16 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus16)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic getDone(input int w);
    return (w == 16) ? bus16.done_tick : bus8.done_tick;
  endfunction

  function automatic logic getReady(input int w);
    return (w == 16) ? bus16.ready : bus8.ready;
  endfunction

  function automatic logic getCout(input int w);
    return (w == 16) ? bus16.cout : bus8.cout;
  endfunction

  function automatic logic [31:0] getSum(input int w);
    return (w == 16) ? 32'(bus16.sum) : 32'(bus8.sum);
  endfunction

  // Called at a negedge in IDLE: presents one start pulse, returns at cycle 1's negedge.
  task automatic applyStimulus(input int w, input logic [15:0] a, input logic [15:0] b,
                               input logic cin);
    if (w == 16) begin
      bus16.start = 1'b1; bus16.a = a; bus16.b = b; bus16.cin = cin;
    end else begin
      bus8.start = 1'b1; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.cin = cin;
    end
    @(negedge clk);
    bus8.start  = 1'b0;
    bus16.start = 1'b0;
  endtask

  // Full operation: latency, result, and return of ready in the following cycle.
  task automatic runOp(input string tag, input int w, input logic [15:0] a,
                       input logic [15:0] b, input logic cin,
                       input logic [15:0] expSum, input logic expCout);
    int cyc;
    applyStimulus(w, a, b, cin);
    cyc = 1;
    while (getDone(w) !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_latency"}, cyc, w + 1);
    checkOutput({tag, "_sum"}, getSum(w), {16'h0, expSum});
    checkOutput({tag, "_cout"}, getCout(w), expCout);
    @(negedge clk);
    checkOutput({tag, "_readyBack"}, getReady(w), 1);
    checkOutput({tag, "_doneOnce"}, getDone(w), 0);
  endtask

  initial begin
    $display("[TB] serial_adder_nand directed test start");
    reset_n     = 1'b0;
    bus8.start  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus8.sub  = 1'b0;
    bus16.sub = 1'b0;
`endif
    repeat (2) @(negedge clk);

    checkOutput("rst8_ready", bus8.ready, 1);
    checkOutput("rst8_done", bus8.done_tick, 0);
    checkOutput("rst8_sum", bus8.sum, 0);
    checkOutput("rst8_cout", bus8.cout, 0);
    checkOutput("rst16_ready", bus16.ready, 1);
    checkOutput("rst16_sum", bus16.sum, 0);
    reset_n = 1'b1;

    runOp("add5A33", 8, 16'h5A, 16'h33, 1'b0, 16'h8D, 1'b0);
    runOp("addFF01c", 8, 16'hFF, 16'h01, 1'b1, 16'h01, 1'b1);
    runOp("b2bZero", 8, 16'h00, 16'h00, 1'b0, 16'h00, 1'b0);

    bus8.start = 1'b1; bus8.a = 8'h5A; bus8.b = 8'h33; bus8.cin = 1'b0;
    doneCount = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 5) begin
        bus8.a = 8'h01;
        bus8.b = 8'h01;
      end
      if (bus8.done_tick === 1'b1) doneCount++;
      checkOutput($sformatf("hold_done_c%0d", i), bus8.done_tick, (i == 9 || i == 19));
      if (i == 9) begin
        checkOutput("hold_sum1", bus8.sum, 8'h8D);
        checkOutput("hold_cout1", bus8.cout, 0);
      end
      if (i == 19) checkOutput("hold_sum2", bus8.sum, 8'h02);
    end
    bus8.start = 1'b0;
    checkOutput("hold_doneCount", doneCount, 2);
    checkOutput("hold_readyEnd", bus8.ready, 1);

    bus8.a = 8'h5A; bus8.b = 8'h33; bus8.cin = 1'b0;
    applyStimulus(8, 16'h5A, 16'h33, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("midRst_ready", bus8.ready, 1);
    checkOutput("midRst_sum", bus8.sum, 0);
    checkOutput("midRst_cout", bus8.cout, 0);
    checkOutput("midRst_done", bus8.done_tick, 0);
    quietDone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done_tick === 1'b1) quietDone++;
    end
    checkOutput("midRst_noDone", quietDone, 0);
    runOp("add1234", 8, 16'h12, 16'h34, 1'b0, 16'h46, 1'b0);

    runOp("w16FFFF", 16, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);

`ifdef SERIAL_ADDER_SUB_EN
    bus8.sub = 1'b1;
    runOp("sub1020", 8, 16'h10, 16'h20, 1'b1, 16'hF0, 1'b0);
    runOp("sub2010", 8, 16'h20, 16'h10, 1'b0, 16'h10, 1'b1);
    bus8.sub = 1'b0;
    runOp("subOffAdd", 8, 16'h20, 16'h10, 1'b1, 16'h31, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder_nand.md
# serial_adder_nand

Bit-serial, parametrised-width adder built around a single NAND-only full-adder cell and a registered carry. It is the sequential successor of the one-bit NAND full adder. It adds two `N`-bit operands plus carry-in LSB-first, one bit per clock, under a start/done handshake. It sits in datapaths where area matters more than latency, for example accumulators or checksum units.

## Interface
- `N`, default 8: operand width in bits, legal range N ≥ 2.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset_n`, input, 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `start`, input, 1: request; accepted only when `ready`=1.
- `a`, input, N: operand A, sampled on the accepted `start`.
- `b`, input, N: operand B, sampled on the accepted `start`.
- `cin`, input, 1: carry-in, sampled on the accepted `start`.
- `ready`, output, 1: high only in IDLE.
- `done_tick`, output, 1: one-cycle pulse when the result is valid.
- `sum`, output, N: result; valid from `done_tick` until the next accepted `start`.
- `cout`, output, 1: carry-out; same validity as `sum`.

## Operation
- FSM states: IDLE, ADD, DONE. Encoding comes from the package.
- **IDLE**
  - `ready`=1.
  - On `start`=1: load `a_reg`←a, `b_reg`←b, `c_reg`←cin, clear the bit counter, go to ADD.
- **ADD**
  - The cell computes s = a_reg[0]^b_reg[0]^c_reg and co = majority(a_reg[0], b_reg[0], c_reg).
  - `sum_reg` ← {s, sum_reg[N-1:1]}.
  - `a_reg` and `b_reg` shift right by 1.
  - `c_reg` ← co.
  - Counter increments. After the N-th bit, go to DONE.
- **DONE**
  - `done_tick`=1 for exactly this cycle.
  - `cout` = c_reg.
  - Next state is IDLE unconditionally.
- `start` while not in IDLE is ignored. It is neither queued nor allowed to corrupt operands.
- `sum`/`cout` hold their value through IDLE until the next accepted `start`. During ADD, `sum` shows partial shift contents and is not checked.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(N+1). No saturation.
- Counter width is $clog2(N+1). It never wraps within one operation.
- **Reset** (any state, including mid-ADD): state←IDLE, `ready`=1, `done_tick`=0, `sum`=0, `cout`=0, all internal registers cleared.

## Timing
- `start` is accepted in cycle 0.
- ADD occupies cycles 1..N.
- DONE / `done_tick` is in cycle N+1.
- `ready` returns high in cycle N+2.
- Throughput: one operation per N+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `SERIAL_ADDER_SUB_EN`.
- **Defined:**
  - Adds input `sub` (1 bit), sampled with `start`.
  - With sub=1: `b_reg` loads ~b and `c_reg` loads 1, with `cin` ignored. The block then computes a − b in two's complement, and `cout`=1 means no borrow.
  - With sub=0: behaviour is identical to the undefined case.
- **Undefined:** the `sub` port is absent and the block always adds.

## Structure
- `serial_adder_pkg` holds:
  - the state typedef (IDLE/ADD/DONE);
  - the default width constant `SERIAL_ADDER_N_DEF` = 8.
- Sub-module `full_adder_cell`: a purely combinational one-bit full adder built only from `nand_gate` instances (9 NANDs). It is instantiated once in the top level.

## Test plan
- N=8, a=0x5A, b=0x33, cin=0, start pulse → `done_tick` at cycle 9; sum=0x8D, cout=0; `ready` high at cycle 10.
- N=8, a=0xFF, b=0x01, cin=1 → sum=0x01, cout=1. Then a=0x00, b=0x00, cin=0 back-to-back at the first `ready` → sum=0x00, cout=0.
- `start` held high for 20 cycles with fixed operands → exactly one `done_tick` per 10 cycles. Operand change mid-ADD has no effect on the result.
- `reset_n`=0 for one cycle at cycle 4 of ADD → next cycle: ready=1, sum=0, cout=0, no `done_tick`. A subsequent add of 0x12+0x34 gives 0x46.
- N=16, a=0xFFFF, b=0x0000, cin=1 → `done_tick` at cycle 17; sum=0x0000, cout=1.
- With `SERIAL_ADDER_SUB_EN`, N=8:
  - a=0x10, b=0x20, sub=1 → sum=0xF0, cout=0.
  - a=0x20, b=0x10, sub=1 → sum=0x10, cout=1.
